// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between two refill masters.
// AR is registered (1-cycle issue latency); R is routed combinationally to the granted master.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_arvalid_i,
    output logic              m0_arready_o,
    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic [ID_W-1:0]   m0_arid_i,
    input  logic [7:0]        m0_arlen_i,
    input  logic [1:0]        m0_arburst_i,
    input  logic              m1_arvalid_i,
    output logic              m1_arready_o,
    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic [ID_W-1:0]   m1_arid_i,
    input  logic [7:0]        m1_arlen_i,
    input  logic [1:0]        m1_arburst_i,

    output logic              m0_rvalid_o,
    input  logic              m0_rready_i,
    output logic              m1_rvalid_o,
    input  logic              m1_rready_i,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic [1:0]        m_rresp_o,
    output logic [ID_W-1:0]   m_rid_o,
    output logic              m_rlast_o,

    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic [ID_W-1:0]   axi_arid_o,
    output logic [7:0]        axi_arlen_o,
    output logic [1:0]        axi_arburst_o,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]        axi_rresp_i,
    input  logic [ID_W-1:0]   axi_rid_i,
    input  logic              axi_rlast_i,

    output logic              busy_o,
    output logic              grant_o,
    output logic              len_err_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q;
    logic              prio_q;
    logic              grant_q;
    logic              len_err_q;
    logic [7:0]        beat_cnt_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [ID_W-1:0]   ar_id_q;
    logic [7:0]        ar_len_q;
    logic [1:0]        ar_burst_q;

    logic grant_d;
    logic accept;
    logic r_hs;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        grant_d = grant_q;
        if (m0_arvalid_i && m1_arvalid_i) begin
            grant_d = prio_q;
        end else if (m1_arvalid_i) begin
            grant_d = 1'b1;
        end else if (m0_arvalid_i) begin
            grant_d = 1'b0;
        end
    end

    assign accept       = (state_q == IDLE) && (m0_arvalid_i || m1_arvalid_i);
    assign m0_arready_o = accept && !grant_d;
    assign m1_arready_o = accept &&  grant_d;

    assign axi_arvalid_o = (state_q == ADDR);
    assign axi_araddr_o  = ar_addr_q;
    assign axi_arid_o    = ar_id_q;
    assign axi_arlen_o   = ar_len_q;
    assign axi_arburst_o = ar_burst_q;

    assign axi_rready_o = (state_q == DATA) && (grant_q ? m1_rready_i : m0_rready_i);
    assign m0_rvalid_o  = (state_q == DATA) && !grant_q && axi_rvalid_i;
    assign m1_rvalid_o  = (state_q == DATA) &&  grant_q && axi_rvalid_i;
    assign r_hs         = axi_rvalid_i && axi_rready_o;

    assign m_rdata_o = axi_rdata_i;
    assign m_rresp_o = axi_rresp_i;
    assign m_rid_o   = axi_rid_i;
    assign m_rlast_o = axi_rlast_i;

    assign busy_o    = (state_q != IDLE);
    assign grant_o   = grant_q;
    assign len_err_o = len_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            grant_q    <= 1'b0;
            len_err_q  <= 1'b0;
            beat_cnt_q <= '0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= grant_d;
                        ar_addr_q  <= grant_d ? m1_araddr_i  : m0_araddr_i;
                        ar_id_q    <= grant_d ? m1_arid_i    : m0_arid_i;
                        ar_len_q   <= grant_d ? m1_arlen_i   : m0_arlen_i;
                        ar_burst_q <= grant_d ? m1_arburst_i : m0_arburst_i;
                        beat_cnt_q <= '0;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi_arready_i) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beat_cnt_q != 8'hff) begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                        // Short bursts are caught at rlast, long ones at the beat past arlen.
                        if (axi_rlast_i) begin
                            state_q <= IDLE;
                            prio_q  <= ~grant_q;
                            if (beat_cnt_q != ar_len_q) begin
                                len_err_q <= 1'b1;
                            end
                        end else if (beat_cnt_q == ar_len_q) begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: queued AR/R expectations checked against the DUT outputs.
module tb_axi_rd_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_arvalid_i, m0_arready_o, m1_arvalid_i, m1_arready_o;
    logic [31:0] m0_araddr_i, m1_araddr_i;
    logic [3:0]  m0_arid_i, m1_arid_i;
    logic [7:0]  m0_arlen_i, m1_arlen_i;
    logic [1:0]  m0_arburst_i, m1_arburst_i;
    logic        m0_rvalid_o, m0_rready_i, m1_rvalid_o, m1_rready_i;
    logic [31:0] m_rdata_o;
    logic [1:0]  m_rresp_o;
    logic [3:0]  m_rid_o;
    logic        m_rlast_o;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;
    logic        axi_rlast_i;
    logic        busy_o, grant_o, len_err_o;

    axi_rd_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o), .m0_araddr_i(m0_araddr_i),
        .m0_arid_i(m0_arid_i), .m0_arlen_i(m0_arlen_i), .m0_arburst_i(m0_arburst_i),
        .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o), .m1_araddr_i(m1_araddr_i),
        .m1_arid_i(m1_arid_i), .m1_arlen_i(m1_arlen_i), .m1_arburst_i(m1_arburst_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
        .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rid_o(m_rid_o), .m_rlast_o(m_rlast_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
        .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
        .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i),
        .busy_o(busy_o), .grant_o(grant_o), .len_err_o(len_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    ar_exp_t arq[$];
    r_exp_t  rq[$];
    int      checks = 0;
    int      errors = 0;
    logic    exp_prio = 1'b0;
    logic    exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst: req is the set of masters driving arvalid in the IDLE cycle.
    task automatic burst(input logic [1:0] req, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input int ar_delay, input int stall_beat, input int rst_beat);
        logic    g;
        ar_exp_t ea;
        r_exp_t  er;
        @(negedge clk_i);
        axi_rvalid_i = 1'b0;
        axi_rlast_i  = 1'b0;
        m0_arvalid_i = req[0];
        m1_arvalid_i = req[1];
        m0_araddr_i  = addr;
        m1_araddr_i  = addr ^ 32'h8000;
        m0_arlen_i   = len;
        m1_arlen_i   = len;
        g = (req == 2'b11) ? exp_prio : req[1];
        arq.push_back(g ? ar_exp_t'{addr ^ 32'h8000, 4'h9, len, 2'b10}
                        : ar_exp_t'{addr, 4'h2, len, 2'b01});
        #1;
        chk("idle_busy", busy_o, 1'b0);
        chk("len_err", len_err_o, exp_err);
        chk("arready0", m0_arready_o, !g);
        chk("arready1", m1_arready_o, g);

        @(negedge clk_i);
        if (g) m1_arvalid_i = 1'b0;
        else   m0_arvalid_i = 1'b0;
        ea = arq.pop_front();
        for (int d = 0; d <= ar_delay; d++) begin
            if (d > 0) @(negedge clk_i);
            axi_arready_i = (d == ar_delay);
            axi_rvalid_i  = 1'b1;
            #1;
            chk("arvalid", axi_arvalid_o, 1'b1);
            chk("araddr", axi_araddr_o, ea.addr);
            chk("arid", axi_arid_o, ea.id);
            chk("arlen", axi_arlen_o, ea.len);
            chk("arburst", axi_arburst_o, ea.burst);
            chk("grant", grant_o, g);
            chk("addr_busy", busy_o, 1'b1);
            chk("addr_arready", {m0_arready_o, m1_arready_o}, 2'b00);
            chk("addr_rready", axi_rready_o, 1'b0);
            chk("addr_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
        end

        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk_i);
            axi_arready_i = 1'b0;
            axi_rvalid_i  = 1'b1;
            axi_rdata_i   = $urandom;
            axi_rresp_i   = 2'(b);
            axi_rid_i     = ea.id;
            axi_rlast_i   = (b == nbeats - 1);
            rq.push_back(r_exp_t'{axi_rdata_i, axi_rresp_i, axi_rlast_i});
            if (b == rst_beat) begin
                rst_ni = 1'b0;
                #1;
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_arvalid", axi_arvalid_o, 1'b0);
                chk("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
                chk("rst_rready", axi_rready_o, 1'b0);
                chk("rst_grant", grant_o, 1'b0);
                chk("rst_len_err", len_err_o, 1'b0);
                rq.delete();
                exp_prio = 1'b0;
                exp_err  = 1'b0;
                @(negedge clk_i);
                axi_rvalid_i = 1'b0;
                rst_ni = 1'b1;
                return;
            end
            if (b == stall_beat) begin
                if (g) m1_rready_i = 1'b0;
                else   m0_rready_i = 1'b0;
                #1;
                chk("stall_rready", axi_rready_o, 1'b0);
                chk("stall_rvalid", g ? m1_rvalid_o : m0_rvalid_o, 1'b1);
                @(negedge clk_i);
                m0_rready_i = 1'b1;
                m1_rready_i = 1'b1;
            end
            #1;
            chk("rvalid_own", g ? m1_rvalid_o : m0_rvalid_o, 1'b1);
            chk("rvalid_other", g ? m0_rvalid_o : m1_rvalid_o, 1'b0);
            chk("rready", axi_rready_o, 1'b1);
            er = rq.pop_front();
            chk("rdata", m_rdata_o, er.data);
            chk("rresp", m_rresp_o, er.resp);
            chk("rid", m_rid_o, ea.id);
            chk("rlast", m_rlast_o, er.last);
        end
        exp_prio = !g;
        if (nbeats != int'(len) + 1) exp_err = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        m0_arvalid_i = 1'b0; m1_arvalid_i = 1'b0;
        m0_araddr_i = '0;    m1_araddr_i = '0;
        m0_arid_i = 4'h2;    m1_arid_i = 4'h9;
        m0_arlen_i = '0;     m1_arlen_i = '0;
        m0_arburst_i = 2'b01; m1_arburst_i = 2'b10;
        m0_rready_i = 1'b1;  m1_rready_i = 1'b1;
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0;
        axi_rdata_i = '0; axi_rresp_i = '0; axi_rid_i = '0; axi_rlast_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_arvalid", axi_arvalid_o, 1'b0);
        chk("reset_grant", grant_o, 1'b0);
        chk("reset_len_err", len_err_o, 1'b0);
        chk("reset_rready", axi_rready_o, 1'b0);
        rst_ni = 1'b1;

        // Tie after reset: m0, then m1, then m0 again.
        burst(2'b11, 32'h0000_2000, 8'd7, 8, 0, -1, -1);
        burst(2'b11, 32'h0000_2100, 8'd7, 8, 0, -1, -1);
        burst(2'b11, 32'h0000_2200, 8'd7, 8, 0, -1, -1);
        // m1 still waiting: AR back-pressure for 5 cycles and an R stall on beat 3.
        burst(2'b10, 32'h0000_2300, 8'd7, 8, 5, 3, -1);
        // Single master.
        burst(2'b01, 32'h0000_1000, 8'd7, 8, 0, -1, -1);
        // Short burst: rlast on beat 5 of a len-7 request, then a correct burst.
        burst(2'b01, 32'h0000_3000, 8'd7, 6, 0, -1, -1);
        burst(2'b10, 32'h0000_4000, 8'd7, 8, 1, -1, -1);
        // Reset during beat 4, then a fresh m1 request.
        burst(2'b01, 32'h0000_5000, 8'd7, 8, 0, -1, 4);
        burst(2'b10, 32'h0000_6000, 8'd3, 4, 0, -1, -1);

        @(negedge clk_i);
        axi_rvalid_i = 1'b0;
        axi_rlast_i  = 1'b0;
        #1;
        chk("end_busy", busy_o, 1'b0);
        chk("end_len_err", len_err_o, exp_err);
        chk("end_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI4 read channel of the CPU memory port between two refill masters: master 0 (instruction cache) and master 1 (data cache). Each master issues one read burst, typically an 8-beat INCR line refill. The block grants one burst at a time with round-robin priority and registers the AR request toward memory. It routes R beats back to the granted master and flags bursts whose beat count does not match the requested length. It sits between the cache refill ports and the top-level AXI read interface. It touches only the AR and R channels; write channels are outside its scope.

## Interface
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width
- ID_W, 4, AR/R ID width
- clk_i  in  1  clock; all state changes on its rising edge
- rst_ni  in  1  reset, asynchronous and active-low
- m0_arvalid_i, m1_arvalid_i  in  1  burst request from master 0 / master 1
- m0_arready_o, m1_arready_o  out  1  request accepted (one-cycle pulse)
- m0_araddr_i, m1_araddr_i  in  ADDR_W  burst start address
- m0_arid_i, m1_arid_i  in  ID_W  burst ID
- m0_arlen_i, m1_arlen_i  in  8  beats minus 1
- m0_arburst_i, m1_arburst_i  in  2  burst type
- m0_rvalid_o, m1_rvalid_o  out  1  R beat valid for that master
- m0_rready_i, m1_rready_i  in  1  master ready for an R beat
- m_rdata_o  out  DATA_W  R data, shared by both masters
- m_rresp_o  out  2  R response, shared
- m_rid_o  out  ID_W  R ID, shared
- m_rlast_o  out  1  R last, shared
- axi_arvalid_o, axi_arready_i, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arburst_o  AXI AR channel toward memory (out, in, out ADDR_W, out ID_W, out 8, out 2)
- axi_rvalid_i, axi_rready_o, axi_rdata_i, axi_rresp_i, axi_rid_i, axi_rlast_i  AXI R channel from memory (in, out, in DATA_W, in 2, in ID_W, in 1)
- busy_o  out  1  a burst is granted (state is not IDLE)
- grant_o  out  1  index of the granted master; holds its last value while IDLE
- len_err_o  out  1  sticky flag: a burst ended with the wrong number of beats

## Operation
- The state machine has three states: IDLE, ADDR, DATA. It resets to IDLE.
- Registers and their reset values: prio_q = 0 (master 0 preferred), grant_q = 0, beat_cnt_q = 0, len_err_q = 0, and the AR holding registers = 0.
- IDLE:
  - If exactly one arvalid is high, grant that master.
  - If both are high, grant master prio_q.
  - In that same cycle: pulse the granted master's arready, load grant_q, and copy its addr/id/len/burst into the AR registers. Set beat_cnt_q to 0 and go to ADDR.
- ADDR:
  - axi_arvalid_o = 1, with registered fields held stable.
  - On axi_arready_i, go to DATA.
  - Both master arready outputs stay 0.
- DATA:
  - The granted master receives the memory R beats: its rvalid = axi_rvalid_i, and axi_rready_o = that master's rready.
  - The other master's rvalid is 0.
  - The m_r* outputs always pass axi_r* through combinationally.
  - Each handshake (axi_rvalid_i & axi_rready_o) increments beat_cnt_q.
  - On a handshake with axi_rlast_i: go to IDLE and set prio_q to the other master. If beat_cnt_q != arlen, set len_err_q.
  - If a handshake without rlast occurs when beat_cnt_q == arlen, set len_err_q. The burst continues until rlast arrives.
  - beat_cnt_q saturates at 255.
- Requests arriving in ADDR or DATA are not accepted. The master must keep arvalid high; the arbiter re-evaluates in the next IDLE cycle.
- axi_rready_o = 0 and both master rvalid outputs = 0 outside DATA.
- R beats arriving outside DATA are not accepted (they stall).
- rresp errors are passed through unchanged and do not affect the FSM.
- Reset asserted mid-burst clears all state immediately. All outputs return to their reset values: arvalid, arready, rvalid, rready, busy, len_err = 0, grant_o = 0.

## Timing
- Request acceptance: the arready pulse occurs in the same cycle arvalid is sampled in IDLE.
- axi_arvalid_o rises in the following cycle, so AR issue latency is 1 cycle.
- Minimum cycles per burst: 1 (IDLE) + 1 (ADDR, when arready is immediate) + (arlen+1) beats.
- A new grant can occur in the cycle after the rlast handshake, because the FSM is in IDLE then.
- The R path is purely combinational, so it adds zero latency.
- axi_arvalid_o never drops before axi_arready_i, and the AR fields never change while axi_arvalid_o is high.

## Test plan
- Single master: m0 requests addr 0x1000, len 7. m0_arready pulses in cycle 0. axi_arvalid_o = 1 in cycle 1 with addr 0x1000 and len 7. With axi_arready_i immediate, 8 beats route to m0 and m1_rvalid stays 0. busy_o falls after rlast.
- Both masters request in the same IDLE cycle after reset: m0 is granted first (prio_q = 0), then m1 after m0's rlast. With both still requesting, the third grant goes to m0.
- Back-pressure: axi_arready_i held low for 5 cycles keeps axi_arvalid_o and all AR fields stable. With m1_rready low on beat 3, axi_rready_o is 0 for that cycle and beat_cnt_q does not advance.
- Length error: len 7 requested, rlast arrives on beat 5 → len_err_o = 1, stays 1 through the next correct burst, and FSM returns to IDLE.
- Reset mid-burst: rst_ni driven low during beat 4 → busy_o = 0, axi_arvalid_o = 0, and all rvalid outputs = 0 immediately. After release, a fresh m1 request is granted in its first IDLE cycle.
